// File: rtl/mac_test_pkg.sv
// Shared constants, FSM state type and LFSR helpers for the MAC self-test monitor.
package mac_test_pkg;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] C_MASK    = 16'h5A5A;
   localparam int unsigned SUM_EXT   = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_t;

   // Galois right-shift step, x^16+x^14+x^13+x^11+1
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   function automatic logic [15:0] bit_rev(input logic [15:0] s);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) begin
         r[i] = s[15-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/mac_operand_lfsr.sv
// Pseudo-random operand source: LFSR plus registered a/b/c derivation for both MACs.
module mac_operand_lfsr
   import mac_test_pkg::*;
#(
   parameter int unsigned W    = 16,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic         i_step,
   output logic [W-1:0] o_a,
   output logic [W-1:0] o_b,
   output logic [W-1:0] o_c
);

   // r_lfsr always holds the state of the next vector to issue
   logic [15:0]  r_lfsr;
   logic [15:0]  w_src;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic [W-1:0] r_c;

   assign w_src = i_load ? SEED : r_lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
         r_a    <= '0;
         r_b    <= '0;
         r_c    <= '0;
      end else if (i_load || i_step) begin
         r_lfsr <= lfsr_step(w_src);
         r_a    <= w_src;
         r_b    <= bit_rev(w_src);
         r_c    <= w_src ^ C_MASK;
      end
   end

   assign o_a = r_a;
   assign o_b = r_b;
   assign o_c = r_c;

endmodule

// File: rtl/mac_error_monitor.sv
// On-chip stimulus generator and error-statistics checker for an exact vs approximate MAC pair.
module mac_error_monitor
   import mac_test_pkg::*;
#(
   parameter int unsigned INPUT_SIZE = 16,
   parameter int unsigned N_VECTORS  = 1024,
   parameter int unsigned LAT        = 0,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   output logic [INPUT_SIZE-1:0]              a_out,
   output logic [INPUT_SIZE-1:0]              b_out,
   output logic [INPUT_SIZE-1:0]              c_out,
   input  logic [2*INPUT_SIZE-1:0]            r_exact,
   input  logic [2*INPUT_SIZE-1:0]            r_approx,
   output logic                               busy,
   output logic                               done,
   output logic [16:0]                        mismatch_cnt,
   output logic [2*INPUT_SIZE-1:0]            max_err,
   output logic [2*INPUT_SIZE+SUM_EXT-1:0]    sum_err
);

   localparam int unsigned ResW      = 2 * INPUT_SIZE;
   localparam int unsigned SumW      = ResW + SUM_EXT;
   localparam logic [16:0] LastIssue = 17'(N_VECTORS);
   localparam logic [2:0]  LastDrain = 3'(LAT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [16:0]       r_issue_cnt;
   logic [2:0]        r_drain_cnt;
   logic              r_done;
   logic              w_start_acc;
   logic              w_last_issue;
   logic              w_step;
   logic              w_issue_vld;
   logic              w_sample_vld;
   logic [ResW-1:0]   w_err;
   logic [16:0]       r_mm;
   logic [ResW-1:0]   r_max;
   logic [SumW-1:0]   r_sum;

   // In DONE, start only counts once done is visible, so a pulse on the done edge is dropped
   assign w_start_acc  = start && ((r_state == StIdle) || ((r_state == StDone) && r_done));
   assign w_last_issue = (r_issue_cnt == LastIssue);
   assign w_issue_vld  = (r_state == StRun);
   assign w_step       = w_issue_vld && !w_last_issue;

   mac_operand_lfsr #(
      .W    (INPUT_SIZE),
      .SEED (SEED)
   ) u_operands (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_start_acc),
      .i_step (w_step),
      .o_a    (a_out),
      .o_b    (b_out),
      .o_c    (c_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_start_acc) w_state_nxt = StRun;
         StRun:   if (w_last_issue) w_state_nxt = (LAT == 0) ? StDone : StDrain;
         StDrain: if (r_drain_cnt == LastDrain) w_state_nxt = StDone;
         StDone:  if (w_start_acc) w_state_nxt = StRun;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      busy = (r_state == StRun) || (r_state == StDrain);
      done = r_done;
   end

   // Issue count includes the vector currently on the operand outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_issue_cnt <= '0;
         r_drain_cnt <= '0;
         r_done      <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_issue_cnt <= 17'd1;
         end else if (w_step) begin
            r_issue_cnt <= r_issue_cnt + 17'd1;
         end
         r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 3'd1 : 3'd0;
         if (w_start_acc) begin
            r_done <= 1'b0;
         end else if (r_state == StDone) begin
            r_done <= 1'b1;
         end
      end
   end

   generate
      if (LAT == 0) begin : g_no_lat
         assign w_sample_vld = w_issue_vld;
      end else begin : g_lat
         logic [LAT-1:0] r_vld;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= '0;
            end else begin
               r_vld[0] <= w_issue_vld;
               for (int i = 1; i < LAT; i++) begin
                  r_vld[i] <= r_vld[i-1];
               end
            end
         end
         assign w_sample_vld = r_vld[LAT-1];
      end
   endgenerate

   assign w_err = (r_exact >= r_approx) ? (r_exact - r_approx) : (r_approx - r_exact);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mm  <= '0;
         r_max <= '0;
         r_sum <= '0;
      end else if (w_start_acc) begin
         r_mm  <= '0;
         r_max <= '0;
         r_sum <= '0;
      end else if (w_sample_vld) begin
         r_mm  <= r_mm + 17'(w_err != '0);
         if (w_err > r_max) begin
            r_max <= w_err;
         end
         r_sum <= r_sum + SumW'(w_err);
      end
   end

   assign mismatch_cnt = r_mm;
   assign max_err      = r_max;
   assign sum_err      = r_sum;

endmodule

// File: tb/tb_mac_error_monitor.sv
// Directed self-checking bench: one LAT=0 and one LAT=2 monitor, each with a bench-side MAC model.
module tb_mac_error_monitor;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start0 = 1'b0;
   logic        start2 = 1'b0;
   logic [15:0] a0, b0, c0, a2, b2, c2;
   logic [31:0] ex0, ap0, ex2, ap2, p1_ex, p1_ap, p2_ex, p2_ap;
   logic        busy0, done0, busy2, done2;
   logic [16:0] mm0, mm2;
   logic [31:0] mx0, mx2;
   logic [47:0] sm0, sm2;
   int          mode = 0;
   logic [15:0] v3a;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      bit sel;
      int mode;
      int mm;
      int mx;
      int sm;
      int edges;
      int busy;
   } row_t;
   row_t rows [5];

   always #5 clk = ~clk;

   function automatic logic [15:0] tb_next(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [15:0] tb_rev(input logic [15:0] s);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = s[15-i];
      return r;
   endfunction

   function automatic logic [31:0] ideal(input logic [15:0] a, b, c);
      return {16'b0, a} * {16'b0, b} + {16'b0, c};
   endfunction

   // mode 1: approx = exact-5 always; mode 2: +100 only on vector 3
   function automatic logic [31:0] approx(input logic [31:0] ex, input logic [15:0] a);
      return ex - ((mode == 1) ? 32'd5 : 32'd0) + ((mode == 2 && a == v3a) ? 32'd100 : 32'd0);
   endfunction

   always_comb begin
      ex0 = ideal(a0, b0, c0);
      ap0 = approx(ex0, a0);
      ex2 = ideal(a2, b2, c2);
      ap2 = approx(ex2, a2);
   end

   always_ff @(posedge clk) begin
      p1_ex <= ex2;
      p1_ap <= ap2;
      p2_ex <= p1_ex;
      p2_ap <= p1_ap;
   end

   mac_error_monitor #(
      .INPUT_SIZE (16),
      .N_VECTORS  (8),
      .LAT        (0),
      .SEED       (16'hACE1)
   ) u_dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start0),
      .a_out        (a0),
      .b_out        (b0),
      .c_out        (c0),
      .r_exact      (ex0),
      .r_approx     (ap0),
      .busy         (busy0),
      .done         (done0),
      .mismatch_cnt (mm0),
      .max_err      (mx0),
      .sum_err      (sm0)
   );

   mac_error_monitor #(
      .INPUT_SIZE (16),
      .N_VECTORS  (8),
      .LAT        (2),
      .SEED       (16'hACE1)
   ) u_dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start2),
      .a_out        (a2),
      .b_out        (b2),
      .c_out        (c2),
      .r_exact      (p2_ex),
      .r_approx     (p2_ap),
      .busy         (busy2),
      .done         (done2),
      .mismatch_cnt (mm2),
      .max_err      (mx2),
      .sum_err      (sm2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic pulse(input bit sel);
      @(negedge clk);
      if (sel) start2 = 1'b1;
      else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   // Call in cycle k+1; edges = posedges from edge k to the rise of done
   task automatic wait_done(input bit sel, output int edges, output int busy_cyc);
      edges = 0;
      busy_cyc = (sel ? busy2 : busy0) ? 1 : 0;
      while (!(sel ? done2 : done0) && edges < 200) begin
         @(negedge clk);
         edges++;
         if (sel ? busy2 : busy0) busy_cyc++;
      end
   endtask

   task automatic chk_stats(input string tag, input bit sel, input int mm, input int mx,
                            input int sm);
      chk({tag, "_mismatch"}, sel ? mm2 : mm0, mm);
      chk({tag, "_max"}, sel ? mx2 : mx0, mx);
      chk({tag, "_sum"}, sel ? sm2 : sm0, sm);
   endtask

   initial begin
      int e, bc;
      logic [15:0] s, last;

      s = 16'hACE1;
      for (int i = 0; i < 3; i++) s = tb_next(s);
      v3a = s;

      rows[0] = '{sel: 0, mode: 0, mm: 0, mx: 0,   sm: 0,   edges: 9,  busy: 8};
      rows[1] = '{sel: 0, mode: 1, mm: 8, mx: 5,   sm: 40,  edges: 9,  busy: 8};
      rows[2] = '{sel: 1, mode: 2, mm: 1, mx: 100, sm: 100, edges: 11, busy: 10};
      rows[3] = '{sel: 0, mode: 2, mm: 1, mx: 100, sm: 100, edges: 9,  busy: 8};
      rows[4] = '{sel: 1, mode: 1, mm: 8, mx: 5,   sm: 40,  edges: 11, busy: 10};

      repeat (3) @(negedge clk);
      chk("rst_a", a0, 0);
      chk("rst_b", b0, 0);
      chk("rst_c", c0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0);
      chk_stats("rst", 0, 0, 0, 0);
      chk("rst_busy2", busy2, 0);
      rst_n = 1'b1;

      for (int r = 0; r < 5; r++) begin
         mode = rows[r].mode;
         pulse(rows[r].sel);
         wait_done(rows[r].sel, e, bc);
         chk($sformatf("row%0d_done_edge", r), e, rows[r].edges);
         chk($sformatf("row%0d_busy_cycles", r), bc, rows[r].busy);
         chk_stats($sformatf("row%0d", r), rows[r].sel, rows[r].mm, rows[r].mx, rows[r].sm);
      end

      // Inputs change while done is held: statistics must not move
      mode = 2;
      repeat (5) @(negedge clk);
      chk_stats("hold", 1, 8, 5, 40);
      chk("hold_done", done2, 1);

      // Operand sequence against the bench LFSR model
      mode = 0;
      pulse(0);
      chk("vec0_a", a0, 16'hACE1);
      chk("vec0_b", b0, 16'h8735);
      chk("vec0_c", c0, 16'hF6BB);
      s = 16'hACE1;
      last = s;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("vec%0d_a", i), a0, s);
         chk($sformatf("vec%0d_b", i), b0, tb_rev(s));
         chk($sformatf("vec%0d_c", i), c0, s ^ 16'h5A5A);
         last = s;
         s = tb_next(s);
         @(negedge clk);
      end
      wait_done(0, e, bc);
      chk("hold_operand_a", a0, last);

      // start during RUN and on the done edge are both ignored
      mode = 1;
      pulse(0);
      repeat (2) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("run_start_busy", busy0, 1);
      repeat (5) @(negedge clk);
      chk("pre_done", done0, 0);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      chk("edge_start_done", done0, 1);
      chk("edge_start_busy", busy0, 0);
      chk_stats("ign", 0, 8, 5, 40);
      @(negedge clk);
      chk("ign_still_done", done0, 1);
      chk("ign_still_idle", busy0, 0);
      pulse(0);
      chk("restart_done_low", done0, 0);
      chk_stats("restart_clear", 0, 0, 0, 0);
      chk("restart_vec0", a0, 16'hACE1);
      wait_done(0, e, bc);
      chk("restart_done_edge", e, 9);
      chk_stats("restart", 0, 8, 5, 40);

      // Reset in the middle of a run
      pulse(0);
      repeat (4) @(negedge clk);
      chk("pre_rst_mismatch", mm0, 4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a", a0, 0);
      chk("mid_rst_b", b0, 0);
      chk("mid_rst_c", c0, 0);
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_done", done0, 0);
      chk_stats("mid_rst", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", busy0, 0);
      chk("post_rst_done", done0, 0);
      chk("post_rst_a", a0, 0);
      pulse(0);
      chk("post_rst_vec0", a0, 16'hACE1);
      wait_done(0, e, bc);
      chk("post_rst_done_edge", e, 9);
      chk("post_rst_busy_cycles", bc, 8);
      chk_stats("post_rst", 0, 8, 5, 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
